// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU operation codes,
// opcode/funct values, FSM state codes and datapath mux select encodings.
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_NOR  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_WORD = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // State codes kept as plain constants so older tools and netlists can share them.
  typedef logic [3:0] state_t;
  localparam state_t RST_S    = 4'd0;
  localparam state_t FETCH    = 4'd1;
  localparam state_t DECODE   = 4'd2;
  localparam state_t MEMADDR  = 4'd3;
  localparam state_t MEMREAD  = 4'd4;
  localparam state_t MEMWB    = 4'd5;
  localparam state_t MEMWRITE = 4'd6;
  localparam state_t REXEC    = 4'd7;
  localparam state_t RWB      = 4'd8;
  localparam state_t IEXEC    = 4'd9;
  localparam state_t IWB      = 4'd10;
  localparam state_t BRANCH   = 4'd11;
  localparam state_t JUMP     = 4'd12;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_RS = 2'b01;
  localparam logic [1:0] SRCA_RT = 2'b10;

  localparam logic [2:0] SRCB_REGB     = 3'b000;
  localparam logic [2:0] SRCB_FOUR     = 3'b001;
  localparam logic [2:0] SRCB_SEXT     = 3'b010;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT     = 3'b100;
  localparam logic [2:0] SRCB_SHAMT    = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation selector: maps the current control state and the
// instruction fields to the ALUOperation code, and flags supported R-type functs.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  logic [3:0] funct_op;
  logic [3:0] imm_op;

  always_comb begin
    funct_valid = 1'b1;
    funct_op    = ALU_AND;
    case (funct)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_XOR:  funct_op = ALU_XOR;
      FN_NOR:  funct_op = ALU_NOR;
      FN_SLL:  funct_op = ALU_SLL;
      FN_SRL:  funct_op = ALU_SRL;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    imm_op = ALU_AND;
    case (opcode)
      OP_ADDI: imm_op = ALU_ADD;
      OP_ANDI: imm_op = ALU_AND;
      OP_ORI:  imm_op = ALU_OR;
      OP_LUI:  imm_op = ALU_LUI;
      default: imm_op = ALU_AND;
    endcase
  end

  // Address arithmetic (PC+4, branch target, lw/sw address) always uses ADD.
  always_comb begin
    alu_op = ALU_AND;
    case (state)
      FETCH, DECODE, MEMADDR: alu_op = ALU_ADD;
      BRANCH:                 alu_op = ALU_SUB;
      REXEC:                  alu_op = funct_op;
      IEXEC:                  alu_op = imm_op;
      default:                alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes all datapath enables and mux selects from the current state.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit RESET_STATE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUOperation,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       InstrDone,
  output logic       IllegalInstr
);

  localparam state_t RESET_TARGET = RESET_STATE_EN ? RST_S : FETCH;

  state_t state;
  state_t next_state;
  logic   opcode_legal;
  logic   funct_valid;
  logic   branch_taken;

  alu_op_decode u_alu_op_decode (
    .state       (state),
    .opcode      (Opcode),
    .funct       (Funct),
    .alu_op      (ALUOperation),
    .funct_valid (funct_valid)
  );

  always_comb begin
    case (Opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: opcode_legal = 1'b1;
      default:                          opcode_legal = 1'b0;
    endcase
  end

  assign branch_taken = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_TARGET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      RST_S:  next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (Opcode)
          OP_RTYPE:                         next_state = REXEC;
          OP_LW, OP_SW:                     next_state = MEMADDR;
          OP_BEQ, OP_BNE:                   next_state = BRANCH;
          OP_J:                             next_state = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = IEXEC;
          default:                          next_state = FETCH;
        endcase
      end
      MEMADDR: next_state = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: next_state = MEMWB;
      REXEC:   next_state = RWB;
      IEXEC:   next_state = IWB;
      default: next_state = FETCH;
    endcase
  end

  // Every output defaults low so RST_S and unused encodings drive an idle datapath.
  always_comb begin
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REGB;
    PCWrite      = 1'b0;
    PCSource     = PCSRC_ALU;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      DECODE: begin
        ALUSrcB = SRCB_SEXT_SH2;
        if (!opcode_legal) begin
          IllegalInstr = 1'b1;
          InstrDone    = 1'b1;
        end
      end
      REXEC: begin
        if (is_shift(Funct)) begin
          ALUSrcA = SRCA_RT;
          ALUSrcB = SRCB_SHAMT;
        end else begin
          ALUSrcA = SRCA_RS;
          ALUSrcB = SRCB_REGB;
        end
      end
      RWB: begin
        RegDst       = 1'b1;
        RegWrite     = funct_valid;
        IllegalInstr = !funct_valid;
        InstrDone    = 1'b1;
      end
      IEXEC: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = (Opcode == OP_ADDI) ? SRCB_SEXT : SRCB_ZEXT;
      end
      IWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMADDR: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_SEXT;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWRITE: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_RS;
        ALUSrcB   = SRCB_REGB;
        PCSource  = PCSRC_ALUOUT;
        PCWrite   = branch_taken;
        InstrDone = 1'b1;
      end
      JUMP: begin
        PCSource  = PCSRC_JUMP;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
      end
      default: begin
        ALUSrcA = SRCA_PC;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model queues the
// expected per-cycle control vector, and a negedge monitor compares each cycle.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUOperation;
  logic [1:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
  logic       InstrDone, IllegalInstr;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .ALUOperation(ALUOperation), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCWrite(PCWrite), .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord, mr, mw, irw, rw, rd, m2r, done, ill;
  } outs_t;

  typedef struct {
    outs_t o;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic outs_t dut_outs();
    outs_t o;
    o = '{alu: ALUOperation, srca: ALUSrcA, srcb: ALUSrcB, pcw: PCWrite, pcs: PCSource,
          iord: IorD, mr: MemRead, mw: MemWrite, irw: IRWrite, rw: RegWrite,
          rd: RegDst, m2r: MemtoReg, done: InstrDone, ill: IllegalInstr};
    return o;
  endfunction

  function automatic outs_t idle();
    outs_t o;
    o = '0;
    return o;
  endfunction

  // ALU code and legality of an R-type funct, straight from the instruction table.
  function automatic void funct_info(input logic [5:0] fn, output logic [3:0] code,
                                     output logic ok);
    ok = 1'b1;
    case (fn)
      6'd32:   code = 4'd3;
      6'd34:   code = 4'd4;
      6'd36:   code = 4'd0;
      6'd37:   code = 4'd1;
      6'd38:   code = 4'd5;
      6'd39:   code = 4'd2;
      6'd0:    code = 4'd8;
      6'd2:    code = 4'd9;
      default: begin code = 4'd0; ok = 1'b0; end
    endcase
  endfunction

  task automatic push(input outs_t o, input string tag);
    exp_t e;
    e.o = o;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_fetch();
    outs_t o = '0;
    o.alu = 4'd3; o.srcb = 3'b001; o.pcw = 1'b1; o.mr = 1'b1; o.irw = 1'b1;
    push(o, "fetch");
  endtask

  // Reference model: the full cycle-by-cycle control vector of one instruction.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            output int n);
    outs_t d, x, w;
    logic [3:0] code;
    logic ok;
    push_fetch();
    d = '0; d.alu = 4'd3; d.srcb = 3'b011;
    x = '0; w = '0;
    n = 4;
    case (op)
      6'b000000: begin
        funct_info(fn, code, ok);
        x.alu = code;
        if (fn == 6'd0 || fn == 6'd2) begin x.srca = 2'b10; x.srcb = 3'b101; end
        else begin x.srca = 2'b01; x.srcb = 3'b000; end
        w.rd = 1'b1; w.rw = ok; w.ill = !ok; w.done = 1'b1;
        push(d, "r_decode"); push(x, "rexec"); push(w, "rwb");
      end
      6'b100011, 6'b101011: begin
        x.srca = 2'b01; x.srcb = 3'b010; x.alu = 4'd3;
        push(d, "m_decode"); push(x, "memaddr");
        if (op == 6'b100011) begin
          w.mr = 1'b1; w.iord = 1'b1;
          push(w, "memread");
          w = '0; w.m2r = 1'b1; w.rw = 1'b1; w.done = 1'b1;
          push(w, "memwb");
          n = 5;
        end else begin
          w.mw = 1'b1; w.iord = 1'b1; w.done = 1'b1;
          push(w, "memwrite");
        end
      end
      6'b000100, 6'b000101: begin
        x.srca = 2'b01; x.srcb = 3'b000; x.alu = 4'd4; x.pcs = 2'b01; x.done = 1'b1;
        x.pcw = (op == 6'b000100) ? z : !z;
        push(d, "b_decode"); push(x, "branch");
        n = 3;
      end
      6'b000010: begin
        x.pcs = 2'b10; x.pcw = 1'b1; x.done = 1'b1;
        push(d, "j_decode"); push(x, "jump");
        n = 3;
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001111: begin
        x.srca = 2'b01;
        x.srcb = (op == 6'b001000) ? 3'b010 : 3'b100;
        x.alu  = (op == 6'b001000) ? 4'd3 : (op == 6'b001100) ? 4'd0 :
                 (op == 6'b001101) ? 4'd1 : 4'd7;
        w.rw = 1'b1; w.done = 1'b1;
        push(d, "i_decode"); push(x, "iexec"); push(w, "iwb");
      end
      default: begin
        d.ill = 1'b1; d.done = 1'b1;
        push(d, "illegal_decode");
        n = 2;
      end
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n;
    Opcode = op; Funct = fn; Zero = z;
    push_instr(op, fn, z, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      outs_t a;
      e = exp_q.pop_front();
      a = dut_outs();
      n_tests++;
      if (a !== e.o) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h required %h", e.tag, $time, a, e.o);
      end
    end
  end

  logic [5:0] legal_ops [10] = '{6'o00, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001111};
  logic [5:0] legal_fns [8]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd0, 6'd2};

  initial begin
    logic [5:0] op, fn;
    outs_t a;
    reset = 1'b0; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0;
    push(idle(), "reset_held");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push(idle(), "rst_s");
    @(posedge clk);
    #1;

    run_instr(6'b000000, 6'b100010, 1'b0);
    run_instr(6'b000000, 6'b000010, 1'b1);
    run_instr(6'b000000, 6'b000000, 1'b0);
    run_instr(6'b000000, 6'b111111, 1'b0);
    run_instr(6'b100011, 6'b010101, 1'b0);
    run_instr(6'b101011, 6'b000000, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b0);
    run_instr(6'b000101, 6'b000000, 1'b1);
    run_instr(6'b000101, 6'b000000, 1'b0);
    run_instr(6'b000010, 6'b000000, 1'b0);
    run_instr(6'b001111, 6'b000000, 1'b0);
    run_instr(6'b001000, 6'b000000, 1'b0);
    run_instr(6'b111111, 6'b000000, 1'b0);

    // Abort an lw in DECODE: outputs must drop immediately, then restart cleanly.
    Opcode = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    push_fetch();
    begin
      outs_t d = '0;
      d.alu = 4'd3; d.srcb = 3'b011;
      push(d, "abort_decode");
    end
    @(posedge clk);
    #7 reset = 1'b0;
    #1;
    a = dut_outs();
    n_tests++;
    if (a !== idle()) begin
      n_fail++;
      $display("FAIL async_abort: got %h required %h", a, idle());
    end
    @(posedge clk);
    #1 reset = 1'b1;
    push(idle(), "rst_s_after_abort");
    @(posedge clk);
    #1;
    run_instr(6'b000000, 6'b100000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 7)];
      run_instr(op, fn, 1'($urandom));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
